// File: rtl/bbot_encoder_sampler.sv
// bbot_encoder_sampler: periodic wheel-counter zeroing, snapshot and saturated velocity with valid/ack handoff
module bbot_encoder_sampler #(
    parameter int PERIOD_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        enable,
    input  logic        zero_req,
    input  logic [31:0] left_count,
    input  logic [31:0] right_count,
    output logic        enc_reset_l,
    output logic [31:0] left_pos,
    output logic [31:0] right_pos,
    output logic [15:0] left_vel,
    output logic [15:0] right_vel,
    output logic        sample_valid,
    input  logic        sample_ack,
    output logic        overrun
);
    typedef enum logic [2:0] {ZERO0, ZERO1, SETTLE, PRIME, IDLE, RUN} state_t;
    localparam int TW = $clog2(PERIOD_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [31:0] MID = 32'h8000_0000;
    state_t state;
    logic [TW-1:0] timer;
    logic [31:0] left_base, right_base;
    function automatic logic [15:0] sat16(input logic [31:0] d);
        return ($signed(d) > 32'sd32767) ? 16'h7fff : ($signed(d) < -32'sd32768) ? 16'h8000 : d[15:0];
    endfunction
    // Sequencer: zero pulse, baseline priming, periodic capture and handshake bookkeeping
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state        <= ZERO0;
            enc_reset_l  <= 1'b0;
            left_pos     <= MID;
            right_pos    <= MID;
            left_vel     <= '0;
            right_vel    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timer        <= '0;
            left_base    <= MID;
            right_base   <= MID;
        end else begin
            if (sample_valid && sample_ack)
                sample_valid <= 1'b0;
            case (state)
                ZERO0: begin
                    state       <= ZERO1;
                    enc_reset_l <= 1'b0;
                end
                ZERO1: begin
                    state       <= SETTLE;
                    enc_reset_l <= 1'b1;
                end
                SETTLE: state <= PRIME;
                default: begin
                    if (zero_req) begin
                        state        <= ZERO0;
                        enc_reset_l  <= 1'b0;
                        sample_valid <= 1'b0;
                        overrun      <= 1'b0;
                        timer        <= '0;
                    end else if (state == PRIME) begin
                        left_base  <= left_count;
                        right_base <= right_count;
                        timer      <= '0;
                        state      <= enable ? RUN : IDLE;
                    end else if (!enable) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (state == IDLE) begin
                        state <= PRIME;
                    end else if (timer == LAST) begin
                        left_pos     <= left_count;
                        right_pos    <= right_count;
                        left_base    <= left_count;
                        right_base   <= right_count;
                        left_vel     <= sat16(left_count - left_base);
                        right_vel    <= sat16(right_count - right_base);
                        timer        <= '0;
                        sample_valid <= 1'b1;
                        overrun      <= overrun | (sample_valid & ~sample_ack);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/bbot_encoder_sampler.md
# bbot_encoder_sampler

Periodic sampling controller for the two wheel quadrature counters (left and right). It zeroes both counters through their synchronous `reset_l` inputs and snapshots both 32-bit counts on a fixed sample period. It also computes a saturated signed per-period delta (wheel velocity) and hands each sample pair to the balance-control logic over a valid/ack handshake. It sits between the two `BBot_SimpleQuadratureCounter` instances and the control/host interface.

## Interface
- `PERIOD_CYCLES`, default 50000: clocks per sample period (1 kHz at 50 MHz); legal range ≥ 4.
- `clock`  in  1  system clock; every register updates on its rising edge.
- `reset_l`  in  1  asynchronous, active-low reset for the whole block.
- `enable`  in  1  high runs periodic sampling; low parks the block in IDLE.
- `zero_req`  in  1  request to re-zero both counters; level-sampled.
- `left_count`  in  32  left counter's `CurrentCount`.
- `right_count`  in  32  right counter's `CurrentCount`.
- `enc_reset_l`  out  1  registered; drives `reset_l` of both counters.
- `left_pos`  out  32  left count captured at the last sample.
- `right_pos`  out  32  right count captured at the last sample.
- `left_vel`  out  16  signed, saturated left delta since the previous sample.
- `right_vel`  out  16  signed, saturated right delta since the previous sample.
- `sample_valid`  out  1  new sample pair is available.
- `sample_ack`  in  1  consumer accepts the sample.
- `overrun`  out  1  sticky; a sample was overwritten before it was acked.

## Operation
- States: ZERO0, ZERO1, SETTLE, PRIME, IDLE, RUN. The asynchronous reset forces ZERO0.
- Reset values:
  - `enc_reset_l`=0.
  - `left_pos`/`right_pos`=0x80000000.
  - `left_vel`/`right_vel`=0.
  - `sample_valid`=0, `overrun`=0.
  - Timer=0, both baselines=0x80000000.
- ZERO0→ZERO1→SETTLE, unconditionally.
  - `enc_reset_l` is low during ZERO0 and ZERO1 (two clocks) and high in every other state.
- SETTLE→PRIME. SETTLE is a one-cycle guard, so the counters are presenting 0x80000000.
- PRIME:
  - baseline_L←`left_count`, baseline_R←`right_count`, timer←0.
  - Next state is RUN if `enable`=1, else IDLE.
- IDLE: timer held at 0. Goes to PRIME when `enable`=1, so velocity is re-baselined after every pause.
- RUN:
  - Timer increments each clock.
  - At the edge where timer==PERIOD_CYCLES-1, a capture happens:
    - pos←count and baseline←count, for both sides.
    - vel←sat16(count − old baseline).
    - timer←0, `sample_valid`←1.
  - `enable`=0 → IDLE and timer←0. No capture occurs on that edge.
- `zero_req`=1 in PRIME, IDLE or RUN → ZERO0 on the next edge.
  - Clears `sample_valid`, `overrun` and the timer.
  - Pos/vel outputs keep their values.
  - `zero_req` is ignored during ZERO0, ZERO1 and SETTLE.
  - `zero_req` has priority over `enable` and over a capture on the same edge.
- Arithmetic:
  - Delta is the 32-bit two's-complement difference, so counter wrap 0xFFFFFFFF→0x00000000 yields +1.
  - Saturate to the range [−32768, +32767].
- Handshake:
  - An edge with `sample_valid`=1 and `sample_ack`=1 clears `sample_valid`.
  - `sample_ack` while `sample_valid`=0 is ignored.
- Overrun:
  - A capture while `sample_valid`=1 and `sample_ack`=0 → new data overwrites, `sample_valid` stays 1, `overrun`←1 (sticky).
  - A capture on the same edge as an ack → new data is loaded, `sample_valid` stays 1, no overrun.

## Timing
- Capture-to-output latency is zero cycles. Outputs and `sample_valid` change on the capture edge and show the counts present before that edge.
- The sample period in RUN is exactly PERIOD_CYCLES clocks.
  - First capture occurs PERIOD_CYCLES clocks after the PRIME edge.
- Reset release to first capture: 4 clocks (ZERO0, ZERO1, SETTLE, PRIME) + PERIOD_CYCLES.
- `zero_req` to `enc_reset_l` low: 1 clock. It is held low for exactly 2 clocks.
- Each counter zeroes on its own clock edge while `enc_reset_l`=0.
- A mid-operation asynchronous reset immediately forces all outputs to their reset values, including `enc_reset_l`=0.

## Test plan
- Reset, PERIOD_CYCLES=10, `enable`=1, counters static:
  - `enc_reset_l` low for 2 clocks.
  - First `sample_valid` 14 clocks after release, with pos=0x80000000 and vel=0 on both sides.
- Left count +5 and right count −3 within one period:
  - Next sample gives `left_vel`=+5, `right_vel`=−3 (0xFFFD).
  - `left_pos`=0x80000005, `right_pos`=0x7FFFFFFD.
- Left count moves 0xFFFFFFFE→0x00000001 between samples → `left_vel`=+3.
- Right count moves +40000 in one period → `right_vel`=0x7FFF. Moving −40000 → 0x8000.
- Never ack two consecutive samples:
  - The second capture sets `overrun`=1 with `sample_valid` still 1.
  - Ack on the exact capture edge gives `sample_valid`=1 with `overrun`=0.
- `zero_req` pulse mid-RUN with `sample_valid`=1:
  - Next edge: `sample_valid`=0, `overrun`=0, `enc_reset_l` low for 2 clocks.
  - Next sample has vel=0 with static counts.
  - `zero_req` pulses during ZERO1 are ignored (exactly 2 low clocks).
